// File: rtl/parity_frame_tx_if.sv
// Word handshake between the producer and the parity frame transmitter.
interface parity_frame_tx_if;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] in_data;
   logic        force_err;

   modport master (output in_valid, output in_data, output force_err, input in_ready);
   modport slave  (input in_valid, input in_data, input force_err, output in_ready);
endinterface

// File: rtl/parity_frame_tx.sv
// Serialises a 16-bit word as a 20-bit frame: start, 16 data bits LSB first,
// group-A parity, group-B parity, stop. One frame in flight at a time.
module parity_frame_tx #(
   parameter int CLKS_PER_BIT = 4,
   parameter bit ODD_PARITY   = 1'b0
) (
   input  logic             CK,
   input  logic             RST,
   parity_frame_tx_if.slave link,
   output logic             tx,
   output logic             busy,
   output logic             done
);

   localparam int            CW       = $clog2(CLKS_PER_BIT + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PAR_A,
      PAR_B,
      STOP
   } state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [3:0]    bit_q, bit_d;
   // Shift register holds {PB, PA, data}; bit 0 is always the next payload bit.
   logic [17:0]   shreg_q, shreg_d;
   logic          done_d;
   logic          tx_d;
   logic          accept;
   logic          bit_end;
   logic          par_a;
   logic          par_b;

   assign accept  = link.in_valid && link.in_ready;
   assign bit_end = (cnt_q == CNT_LAST);
   assign par_a   = (^link.in_data[7:0]) ^ ODD_PARITY ^ link.force_err;
   assign par_b   = (^link.in_data[15:8]) ^ ODD_PARITY;

   // State register: all state plus the registered tx and done outputs.
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge CK) begin
      if (RST) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         bit_q   <= '0;
         shreg_q <= '0;
         tx      <= 1'b1;
         done    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         shreg_q <= shreg_d;
         tx      <= tx_d;
         done    <= done_d;
      end
   end

   // Next-state logic: capture on accept, then step each bit after CLKS_PER_BIT cycles.
   // NOTE: every signal gets a default first so no path leaves it unassigned,
   // which would otherwise infer a latch.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      bit_d   = bit_q;
      shreg_d = shreg_q;
      done_d  = 1'b0;

      if (state_q != IDLE) begin
         cnt_d = bit_end ? '0 : cnt_q + CW'(1);
      end

      case (state_q)
         IDLE: begin
            if (accept) begin
               state_d = START;
               cnt_d   = '0;
               bit_d   = '0;
               shreg_d = {par_b, par_a, link.in_data};
            end
         end
         START: begin
            if (bit_end) state_d = DATA;
         end
         DATA: begin
            if (bit_end) begin
               shreg_d = shreg_q >> 1;
               bit_d   = bit_q + 4'd1;
               if (bit_q == 4'd15) state_d = PAR_A;
            end
         end
         PAR_A: begin
            if (bit_end) begin
               shreg_d = shreg_q >> 1;
               state_d = PAR_B;
            end
         end
         PAR_B: begin
            if (bit_end) state_d = STOP;
         end
         STOP: begin
            if (bit_end) begin
               state_d = IDLE;
               done_d  = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Output logic: handshake/status from the current state, tx value for the next state.
   always_comb begin
      link.in_ready = (state_q == IDLE);
      busy          = (state_q != IDLE);
      case (state_d)
         START:              tx_d = 1'b0;
         DATA, PAR_A, PAR_B: tx_d = shreg_d[0];
         default:            tx_d = 1'b1;
      endcase
   end

endmodule
